// File: rtl/ipsmacge_rx2clk.sv
// ipsmacge_rx2clk: receive-side frame buffer for the GE MAC.
// GMII receive bytes are held in a register-array FIFO, committed only
// when a frame ends cleanly; errored or overflowing frames are rolled back.
// Optional feature macro: IPSMACGE_RXRUNT_EN (drop frames shorter than MINLEN).
module ipsmacge_rx2clk #(
    parameter int ADDRBIT = 4,
    parameter int LENGTH  = 16,
    parameter int MINLEN  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               rxdv,
    input  logic               rxer,
    input  logic [7:0]         rxd,
    input  logic               fiford,
    output logic [7:0]         fifodout,
    output logic               fifoeof,
    output logic               notempty,
    output logic [ADDRBIT:0]   fifolen,
    output logic               frmgood,
    output logic               frmdrop
);

    localparam int PW = ADDRBIT + 1;

    if (LENGTH != (1 << ADDRBIT)) begin : g_bad_length
        $error("LENGTH must equal 2**ADDRBIT");
    end
    if (MINLEN < 1) begin : g_bad_minlen
        $error("MINLEN must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Storage entries are {eof, data}
    logic [8:0]         mem_q [LENGTH];

    state_t             state_q, state_d;
    logic [PW-1:0]      rdptr_q, rdptr_d;
    logic [PW-1:0]      wrptr_c_q, wrptr_c_d;
    logic [PW-1:0]      wrptr_s_q, wrptr_s_d;
    logic [7:0]         stg_q, stg_d;
    logic               stg_v_q, stg_v_d;
    logic               frmgood_q, frmgood_d;
    logic               frmdrop_q, frmdrop_d;

    logic               we_s;
    logic [ADDRBIT-1:0] wa_s;
    logic [8:0]         wd_s;
    logic [PW-1:0]      fill_s;
    logic [PW-1:0]      spec_s;
    logic               space_s;
    logic               runt_s;

    // Occupancy seen by the reader and by the speculative writer
    assign fill_s   = wrptr_c_q - rdptr_q;
    assign spec_s   = wrptr_s_q - rdptr_q;
    assign space_s  = (spec_s < PW'(LENGTH));

    assign fifolen  = fill_s;
    assign notempty = (fill_s != {PW{1'b0}});
    assign fifodout = mem_q[rdptr_q[ADDRBIT-1:0]][7:0];
    assign fifoeof  = mem_q[rdptr_q[ADDRBIT-1:0]][8];
    assign frmgood  = frmgood_q;
    assign frmdrop  = frmdrop_q;

`ifdef IPSMACGE_RXRUNT_EN
    localparam int CW = $clog2(MINLEN + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign runt_s = (cnt_q < CW'(MINLEN));

    // Frame byte counter: restarts on a frame start, saturates at MINLEN
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = {CW{1'b0}};
        end else if ((state_q == ST_IDLE) && rxdv && !rxer) begin
            cnt_d = CW'(1);
        end else if ((state_q == ST_RECV) && rxdv && !rxer && space_s &&
                     (cnt_q < CW'(MINLEN))) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Byte counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign runt_s = 1'b0;
`endif

    // Next-state logic: frame FSM, pointer updates, array write request
    always_comb begin
        state_d   = state_q;
        rdptr_d   = rdptr_q;
        wrptr_c_d = wrptr_c_q;
        wrptr_s_d = wrptr_s_q;
        stg_d     = stg_q;
        stg_v_d   = stg_v_q;
        frmgood_d = 1'b0;
        frmdrop_d = 1'b0;
        we_s      = 1'b0;
        wa_s      = wrptr_s_q[ADDRBIT-1:0];
        wd_s      = {1'b0, stg_q};

        if (fiford && notempty) begin
            rdptr_d = rdptr_q + PW'(1);
        end else begin
            rdptr_d = rdptr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (rxdv && !rxer) begin
                    stg_d   = rxd;
                    stg_v_d = 1'b1;
                    state_d = ST_RECV;
                end else if (rxdv && rxer) begin
                    frmdrop_d = 1'b1;
                    state_d   = ST_DROP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (rxdv && !rxer) begin
                    if (space_s) begin
                        we_s      = 1'b1;
                        wrptr_s_d = wrptr_s_q + PW'(1);
                        stg_d     = rxd;
                    end else begin
                        // Frame cannot fit: discard what was written so far
                        wrptr_s_d = wrptr_c_q;
                        stg_v_d   = 1'b0;
                        frmdrop_d = 1'b1;
                        state_d   = ST_DROP;
                    end
                end else if (rxdv && rxer) begin
                    wrptr_s_d = wrptr_c_q;
                    stg_v_d   = 1'b0;
                    frmdrop_d = 1'b1;
                    state_d   = ST_DROP;
                end else begin
                    // End of frame: the staged byte is the last one
                    if (space_s && stg_v_q && !runt_s) begin
                        we_s      = 1'b1;
                        wd_s      = {1'b1, stg_q};
                        wrptr_s_d = wrptr_s_q + PW'(1);
                        wrptr_c_d = wrptr_s_q + PW'(1);
                        frmgood_d = 1'b1;
                    end else begin
                        wrptr_s_d = wrptr_c_q;
                        frmdrop_d = 1'b1;
                    end
                    stg_v_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!rxdv) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                wrptr_s_d = wrptr_c_q;
                stg_v_d   = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        // Flush overrides everything; a frame in progress is silently discarded
        if (flush) begin
            rdptr_d   = {PW{1'b0}};
            wrptr_c_d = {PW{1'b0}};
            wrptr_s_d = {PW{1'b0}};
            stg_d     = 8'h00;
            stg_v_d   = 1'b0;
            frmgood_d = 1'b0;
            frmdrop_d = 1'b0;
            we_s      = 1'b0;
            if ((state_q == ST_RECV) || (state_q == ST_DROP)) begin
                state_d = ST_DROP;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            state_d = state_d;
        end
    end

    // State, pointer, staging and pulse registers plus the storage array
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rdptr_q   <= {PW{1'b0}};
            wrptr_c_q <= {PW{1'b0}};
            wrptr_s_q <= {PW{1'b0}};
            stg_q     <= 8'h00;
            stg_v_q   <= 1'b0;
            frmgood_q <= 1'b0;
            frmdrop_q <= 1'b0;
            for (int i = 0; i < LENGTH; i++) begin
                mem_q[i] <= 9'h000;
            end
        end else begin
            state_q   <= state_d;
            rdptr_q   <= rdptr_d;
            wrptr_c_q <= wrptr_c_d;
            wrptr_s_q <= wrptr_s_d;
            stg_q     <= stg_d;
            stg_v_q   <= stg_v_d;
            frmgood_q <= frmgood_d;
            frmdrop_q <= frmdrop_d;
            if (we_s) begin
                mem_q[wa_s] <= wd_s;
            end
        end
    end

endmodule
